// File: rtl/led_matrix_scan.sv
// rtl/led_matrix_scan.sv - multiplexed 5x7 LED matrix scan driver with frame-synchronous buffer swap
// Back buffer is written freely; the copy to the front buffer waits for a frame boundary or IDLE.
module led_matrix_scan #(
  parameter int SCAN_DIV       = 20000,
  parameter int BLANK_CYC      = 200,
  parameter bit COL_ACTIVE_LOW = 1'b0,
  parameter bit ROW_ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_col,
  input  logic [6:0] wr_data,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_start,
  output logic [4:0] colOut,
  output logic [6:0] rowOut
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST_CNT    = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] DRIVE_FIRST = CW'(BLANK_CYC);
  localparam logic [4:0]    COL_INACT   = {5{COL_ACTIVE_LOW}};
  localparam logic [6:0]    ROW_INACT   = {7{ROW_ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t          state, state_nx;
  logic [2:0]      col, col_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [4:0][6:0] front, back, front_nx;
  logic            pend, pend_nx;
  logic            ack_nx, fs_nx;
  logic [4:0]      col_drv_nx;
  logic [6:0]      row_drv_nx;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      col   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      col   <= col_nx;
      cnt   <= cnt_nx;
    end
  end

  // Outputs are registered from the next-cycle view so they line up with the state register.
  always_comb begin
    state_nx = state;
    col_nx   = col;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nx = BLANK;
          col_nx   = '0;
          cnt_nx   = '0;
        end
      end
      BLANK: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == BLANK_LAST) state_nx = DRIVE;
      end
      DRIVE: begin
        if (cnt == LAST_CNT) begin
          state_nx = BLANK;
          cnt_nx   = '0;
          col_nx   = (col == 3'd4) ? 3'd0 : col + 3'd1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && !enable) begin
      state_nx = IDLE;
      col_nx   = '0;
      cnt_nx   = '0;
    end

    // swap_ack marks the copy cycle; a request arriving on it merges into that copy.
    pend_nx  = swap_ack ? 1'b0 : (pend | swap_req);
    ack_nx   = pend_nx && ((state_nx == IDLE) ||
               (state_nx == DRIVE && col_nx == 3'd4 && cnt_nx == LAST_CNT));
    front_nx = swap_ack ? back : front;
    fs_nx    = (state_nx == DRIVE) && (col_nx == 3'd0) && (cnt_nx == DRIVE_FIRST);

    col_drv_nx = '0;
    row_drv_nx = '0;
    if (state_nx == DRIVE) begin
      col_drv_nx = 5'b00001 << col_nx;
      row_drv_nx = front_nx[col_nx];
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      front       <= '0;
      back        <= '0;
      pend        <= 1'b0;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
      colOut      <= COL_INACT;
      rowOut      <= ROW_INACT;
    end else begin
      front <= front_nx;
      if (wr_en && wr_col <= 3'd4) back[wr_col] <= wr_data;
      pend        <= pend_nx;
      swap_ack    <= ack_nx;
      frame_start <= fs_nx;
      colOut      <= col_drv_nx ^ COL_INACT;
      rowOut      <= row_drv_nx ^ ROW_INACT;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan.sv
// tb/tb_led_matrix_scan.sv - self-checking bench for led_matrix_scan against a phase-based frame model
module tb_led_matrix_scan;

  localparam int SD = 8;
  localparam int BL = 2;

  logic       CLK, reset_n, enable, wr_en, swap_req;
  logic [2:0] wr_col;
  logic [6:0] wr_data;
  logic       swap_ack, frame_start, swap_ack_l, frame_start_l;
  logic [4:0] colOut, colOut_l;
  logic [6:0] rowOut, rowOut_l;
  logic [13:0] obs, obs_l;

  int nvec, nerr;

  bit         m_run, m_pend, m_copy;
  int         m_ph;
  logic [6:0] m_front [5];
  logic [6:0] m_back  [5];
  logic [4:0] m_col;
  logic [6:0] m_row;
  logic [13:0] exp_v, exp_l;

  led_matrix_scan #(.SCAN_DIV(SD), .BLANK_CYC(BL), .COL_ACTIVE_LOW(1'b0), .ROW_ACTIVE_LOW(1'b0)) u_dut (
    .CLK(CLK), .reset_n(reset_n), .enable(enable), .wr_en(wr_en), .wr_col(wr_col),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start),
    .colOut(colOut), .rowOut(rowOut));

  led_matrix_scan #(.SCAN_DIV(SD), .BLANK_CYC(BL), .COL_ACTIVE_LOW(1'b1), .ROW_ACTIVE_LOW(1'b1)) u_dut_low (
    .CLK(CLK), .reset_n(reset_n), .enable(enable), .wr_en(wr_en), .wr_col(wr_col),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack_l), .frame_start(frame_start_l),
    .colOut(colOut_l), .rowOut(rowOut_l));

  assign obs   = {swap_ack, frame_start, colOut, rowOut};
  assign obs_l = {swap_ack_l, frame_start_l, colOut_l, rowOut_l};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset;
    m_run = 1'b0; m_pend = 1'b0; m_copy = 1'b0; m_ph = 0;
    for (int i = 0; i < 5; i++) begin m_front[i] = 7'h00; m_back[i] = 7'h00; end
    m_col = 5'h00; m_row = 7'h00;
    exp_v = 14'h0000; exp_l = 14'h0FFF;
  endtask

  // Scan position is a flat phase within the 5*SD frame; copies use pre-write back data.
  task automatic model_step;
    int c, off;
    bit drive, fs;
    if (m_copy) for (int i = 0; i < 5; i++) m_front[i] = m_back[i];
    if (wr_en && wr_col < 3'd5) m_back[wr_col] = wr_data;
    m_pend = m_copy ? 1'b0 : (m_pend | swap_req);
    if (!m_run) begin m_run = enable; m_ph = 0; end
    else if (!enable) begin m_run = 1'b0; m_ph = 0; end
    else m_ph = (m_ph + 1) % (5 * SD);
    c     = m_ph / SD;
    off   = m_ph % SD;
    drive = m_run && off >= BL;
    fs    = m_run && m_ph == BL;
    m_copy = m_pend && (!m_run || (drive && c == 4 && off == SD - 1));
    m_col = drive ? 5'(1 << c) : 5'h00;
    m_row = drive ? m_front[c] : 7'h00;
    exp_v = {m_copy, fs, m_col, m_row};
    exp_l = {m_copy, fs, ~m_col, ~m_row};
  endtask

  task automatic tick;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic set_in(input logic en, input logic we, input logic [2:0] wc,
                        input logic [6:0] wd, input logic sr);
    enable = en; wr_en = we; wr_col = wc; wr_data = wd; swap_req = sr;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    set_in(0, 0, 3'd0, 7'h00, 0);
    model_reset();
    repeat (2) @(negedge CLK);
    nvec++;
    if (obs !== 14'h0000 || obs_l !== 14'h0FFF) begin
      nerr++; $display("FAIL reset_state got %h/%h want 0000/0fff", obs, obs_l);
    end
    reset_n = 1'b1;
    set_in(1, 0, 3'd0, 7'h00, 0);
    for (int i = 0; i < 40 && colOut !== 5'b00100; i++) begin
      tick();
      nvec++;
      if (obs !== exp_v || obs_l !== exp_l) begin
        nerr++; $display("FAIL reset_run t=%0t got %h/%h want %h/%h", $time, obs, obs_l, exp_v, exp_l);
      end
    end
    nvec++;
    if (colOut !== 5'b00100) begin
      nerr++; $display("FAIL reset_reach_col2 got colOut=%b want 00100", colOut);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    nvec++;
    if (obs !== 14'h0000 || obs_l !== 14'h0FFF) begin
      nerr++; $display("FAIL reset_async got %h/%h want 0000/0fff", obs, obs_l);
    end
    @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      nvec++;
      if (i < 3 && colOut !== 5'b00000) begin
        nerr++; $display("FAIL reset_first_blank cyc %0d got colOut=%b want 00000", i, colOut);
      end
      if (i == 3 && {frame_start, colOut, rowOut} !== {1'b1, 5'b00001, 7'h00}) begin
        nerr++; $display("FAIL reset_first_drive got fs=%b col=%b row=%h want 1/00001/00", frame_start, colOut, rowOut);
      end
    end
  endtask

  task automatic test_load_and_scan;
    logic [4:0] prev;
    int run_len, first;
    set_in(0, 0, 3'd0, 7'h00, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      set_in(0, 1, 3'(k), 7'(1 << k), 0);
      tick();
      nvec++;
      if (obs !== exp_v || obs_l !== exp_l) begin
        nerr++; $display("FAIL load_write t=%0t got %h/%h want %h/%h", $time, obs, obs_l, exp_v, exp_l);
      end
    end
    set_in(0, 0, 3'd0, 7'h00, 1);
    tick();
    nvec++;
    if (swap_ack !== 1'b1 || swap_ack_l !== 1'b1) begin
      nerr++; $display("FAIL idle_swap_ack got %b/%b want 1", swap_ack, swap_ack_l);
    end
    set_in(0, 0, 3'd0, 7'h00, 0);
    tick();
    nvec++;
    if (swap_ack !== 1'b0) begin
      nerr++; $display("FAIL idle_swap_ack_single got %b want 0", swap_ack);
    end
    set_in(1, 0, 3'd0, 7'h00, 0);
    prev = colOut; run_len = 0; first = 1;
    for (int i = 0; i < 82; i++) begin
      tick();
      nvec++;
      if (obs !== exp_v || obs_l !== exp_l) begin
        nerr++; $display("FAIL scan_model t=%0t got %h/%h want %h/%h", $time, obs, obs_l, exp_v, exp_l);
      end
      for (int k = 0; k < 5; k++) begin
        if (colOut === 5'(1 << k)) begin
          nvec++;
          if (rowOut !== 7'(1 << k)) begin
            nerr++; $display("FAIL scan_row col %0d got %h want %h", k, rowOut, 7'(1 << k));
          end
        end
      end
      if (colOut === 5'b00001) begin
        nvec++;
        if (colOut_l !== 5'b11110 || rowOut_l !== 7'b1111110) begin
          nerr++; $display("FAIL active_low_col0 got %b/%b want 11110/1111110", colOut_l, rowOut_l);
        end
      end
      if (colOut === prev) run_len++;
      else begin
        if (!first) begin
          nvec++;
          if (run_len !== ((prev == 5'b00000) ? BL : SD - BL)) begin
            nerr++; $display("FAIL slot_len col=%b got %0d want %0d", prev, run_len, (prev == 5'b00000) ? BL : SD - BL);
          end
        end
        first = 0; prev = colOut; run_len = 1;
      end
    end
  endtask

  task automatic test_midframe_swap;
    int fr, acks;
    bit ack_prev;
    for (int i = 0; i < 50 && colOut !== 5'b00010; i++) tick();
    nvec++;
    if (colOut !== 5'b00010) begin
      nerr++; $display("FAIL mid_reach_col1 got %b want 00010", colOut);
    end
    set_in(1, 1, 3'd2, 7'h7F, 1);
    tick();
    set_in(1, 0, 3'd0, 7'h00, 0);
    fr = 0; acks = 0; ack_prev = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      nvec++;
      if (obs !== exp_v || obs_l !== exp_l) begin
        nerr++; $display("FAIL mid_model t=%0t got %h/%h want %h/%h", $time, obs, obs_l, exp_v, exp_l);
      end
      if (frame_start) fr++;
      if (colOut === 5'b00100) begin
        nvec++;
        if (rowOut !== ((fr == 0) ? 7'h04 : 7'h7F)) begin
          nerr++; $display("FAIL mid_col2 frame %0d got %h want %h", fr, rowOut, (fr == 0) ? 7'h04 : 7'h7F);
        end
      end
      if (ack_prev && colOut !== 5'b00000) begin
        nerr++; $display("FAIL mid_ack_last_cycle got next colOut=%b want 00000", colOut);
      end
      if (swap_ack) begin
        acks++;
        nvec++;
        if (colOut !== 5'b10000) begin
          nerr++; $display("FAIL mid_ack_col got colOut=%b want 10000", colOut);
        end
      end
      ack_prev = swap_ack;
    end
    nvec++;
    if (acks != 1) begin
      nerr++; $display("FAIL mid_ack_count got %0d want 1", acks);
    end
  endtask

  task automatic test_copy_collision;
    int acks;
    bit after;
    set_in(1, 0, 3'd0, 7'h00, 1);
    tick();
    set_in(1, 0, 3'd0, 7'h00, 0);
    for (int i = 0; i < 50 && !swap_ack; i++) tick();
    nvec++;
    if (swap_ack !== 1'b1) begin
      nerr++; $display("FAIL coll_wait_ack got %b want 1", swap_ack);
    end
    set_in(1, 1, 3'd3, 7'h55, 1);
    tick();
    set_in(1, 0, 3'd0, 7'h00, 0);
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      nvec++;
      if (obs !== exp_v || obs_l !== exp_l) begin
        nerr++; $display("FAIL coll_model t=%0t got %h/%h want %h/%h", $time, obs, obs_l, exp_v, exp_l);
      end
      if (swap_ack) acks++;
      if (colOut === 5'b01000 && rowOut !== 7'h08) begin
        nerr++; $display("FAIL coll_excluded got col3 row %h want 08", rowOut);
      end
    end
    nvec++;
    if (acks != 0) begin
      nerr++; $display("FAIL coll_merged_ack got %0d extra acks want 0", acks);
    end
    set_in(1, 0, 3'd0, 7'h00, 1);
    tick();
    set_in(1, 0, 3'd0, 7'h00, 0);
    acks = 0; after = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      nvec++;
      if (obs !== exp_v || obs_l !== exp_l) begin
        nerr++; $display("FAIL coll2_model t=%0t got %h/%h want %h/%h", $time, obs, obs_l, exp_v, exp_l);
      end
      if (colOut === 5'b01000 && rowOut !== (after ? 7'h55 : 7'h08)) begin
        nerr++; $display("FAIL coll_retained got col3 row %h want %h", rowOut, after ? 7'h55 : 7'h08);
      end
      if (swap_ack) begin acks++; after = 1; end
    end
    nvec++;
    if (acks != 1) begin
      nerr++; $display("FAIL coll2_ack_count got %0d want 1", acks);
    end
  endtask

  task automatic test_enable_drop;
    for (int i = 0; i < 50 && colOut !== 5'b01000; i++) tick();
    set_in(0, 0, 3'd0, 7'h00, 0);
    tick();
    nvec++;
    if (colOut !== 5'b00000 || rowOut !== 7'h00 || colOut_l !== 5'h1F || rowOut_l !== 7'h7F) begin
      nerr++; $display("FAIL drop_inactive got %b/%h low %b/%h want 00000/00 low 11111/7f", colOut, rowOut, colOut_l, rowOut_l);
    end
    repeat (3) tick();
    set_in(1, 0, 3'd0, 7'h00, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      nvec++;
      if (obs !== exp_v || obs_l !== exp_l) begin
        nerr++; $display("FAIL drop_model t=%0t got %h/%h want %h/%h", $time, obs, obs_l, exp_v, exp_l);
      end
      if (i == 3 && (frame_start !== 1'b1 || colOut !== 5'b00001)) begin
        nerr++; $display("FAIL drop_restart got fs=%b col=%b want 1/00001", frame_start, colOut);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
             7'($urandom), $urandom_range(0, 15) == 0);
      tick();
      nvec++;
      if (obs !== exp_v || obs_l !== exp_l) begin
        nerr++; $display("FAIL random t=%0t got %h/%h want %h/%h", $time, obs, obs_l, exp_v, exp_l);
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_load_and_scan();
    test_midframe_swap();
    test_copy_collision();
    test_enable_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
